// File: rtl/systolic_feed_if.sv
// rtl/systolic_feed_if.sv - load, array feed and result signals of the systolic feed controller
interface systolic_feed_if #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int LW = SIZE * DATA_WIDTH;
  localparam int CW = SIZE * SIZE * 2 * DATA_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_a;
  logic [LW-1:0] in_b;
  logic          abort;
  logic          sa_rst_n;
  logic [LW-1:0] sa_a;
  logic [LW-1:0] sa_b;
  logic [CW-1:0] sa_c;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_c;
  logic          busy;

  // controller side
  modport slave (
    input  in_valid, in_a, in_b, abort, sa_c, out_ready,
    output in_ready, sa_rst_n, sa_a, sa_b, out_valid, out_c, busy
  );

  // host / array side
  modport master (
    output in_valid, in_a, in_b, abort, sa_c, out_ready,
    input  in_ready, sa_rst_n, sa_a, sa_b, out_valid, out_c, busy
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - buffers A/B, drives skewed feeds into the systolic array, returns C
module systolic_feed_ctrl #(
  parameter int SIZE         = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_feed_if.slave bus
);
  localparam int LW      = SIZE * DATA_WIDTH;
  localparam int CW      = SIZE * SIZE * 2 * DATA_WIDTH;
  localparam int BW      = $clog2(SIZE);
  localparam int CNT_MAX = (2 * SIZE > DRAIN_CYCLES) ? 2 * SIZE : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t            state;
  logic [BW-1:0]     beat;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  t_nxt;
  logic              clr_n;
  logic              ld_ok;
  logic [LW-1:0]     abuf [SIZE];
  logic [LW-1:0]     bbuf [SIZE];
  logic [LW-1:0]     sa_a_q, sa_b_q;
  logic [LW-1:0]     feed_a_nxt, feed_b_nxt;
  logic              out_valid_q;
  logic [CW-1:0]     out_c_q;

  // array clear is forced low for the whole reset, then follows the registered clear strobe
  assign ld_ok         = ~rst & ((state == IDLE) || (state == LOAD));
  assign bus.in_ready  = ld_ok;
  assign bus.sa_rst_n  = ~rst & clr_n;
  assign bus.sa_a      = sa_a_q;
  assign bus.sa_b      = sa_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;
  assign bus.busy      = (state != IDLE);

  // operand buffers hold stale data across abort/reset; the beat counter decides what is valid
  always_ff @(posedge clk) begin
    if (bus.in_valid && ld_ok && !bus.abort) begin
      abuf[beat] <= bus.in_a;
      bbuf[beat] <= bus.in_b;
    end
  end

  // diagonal skew for the next feed step: lane n carries buffered beat (t - n) when in range
  always_comb begin
    t_nxt      = (state == CLEAR) ? '0 : cnt + CNT_W'(1);
    feed_a_nxt = '0;
    feed_b_nxt = '0;
    for (int n = 0; n < SIZE; n++) begin
      if (int'(t_nxt) >= n && int'(t_nxt) < n + SIZE) begin
        feed_a_nxt[n*DATA_WIDTH +: DATA_WIDTH] = abuf[BW'(int'(t_nxt) - n)][n*DATA_WIDTH +: DATA_WIDTH];
        feed_b_nxt[n*DATA_WIDTH +: DATA_WIDTH] = bbuf[BW'(int'(t_nxt) - n)][n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // sequencer: load -> clear -> skewed feed -> drain -> hold result until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      cnt         <= '0;
      clr_n       <= 1'b1;
      sa_a_q      <= '0;
      sa_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
    end else if (bus.abort) begin
      state       <= IDLE;
      beat        <= '0;
      cnt         <= '0;
      clr_n       <= 1'b0;
      sa_a_q      <= '0;
      sa_b_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      clr_n <= 1'b1;
      case (state)
        IDLE, LOAD: begin
          if (bus.in_valid) begin
            if (beat == BW'(SIZE - 1)) begin
              state <= CLEAR;
              beat  <= '0;
              clr_n <= 1'b0;
            end else begin
              state <= LOAD;
              beat  <= beat + BW'(1);
            end
          end
        end
        CLEAR: begin
          state  <= FEED;
          cnt    <= '0;
          sa_a_q <= feed_a_nxt;
          sa_b_q <= feed_b_nxt;
        end
        FEED: begin
          if (cnt == CNT_W'(2 * SIZE - 2)) begin
            state  <= DRAIN;
            cnt    <= '0;
            sa_a_q <= '0;
            sa_b_q <= '0;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            sa_a_q <= feed_a_nxt;
            sa_b_q <= feed_b_nxt;
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state       <= DONE;
            cnt         <= '0;
            out_c_q     <= bus.sa_c;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - directed bench for systolic_feed_ctrl with an output-stationary array model
module tb_systolic_feed_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  systolic_feed_if #(.SIZE(8), .DATA_WIDTH(8)) bus ();

  systolic_feed_ctrl #(.SIZE(8), .DATA_WIDTH(8), .DRAIN_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 8x8 output-stationary array: A flows right, B flows down, each PE accumulates mod 2^16
  logic [7:0]  pa  [8][8];
  logic [7:0]  pb  [8][8];
  logic [15:0] acc [8][8];
  logic [7:0]  ain, bin;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (!bus.sa_rst_n) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          if (j == 0) ain = bus.sa_a[i*8 +: 8];
          else        ain = pa[i][j-1];
          if (i == 0) bin = bus.sa_b[j*8 +: 8];
          else        bin = pb[i-1][j];
          acc[i][j] <= acc[i][j] + ain * bin;
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
      end
    end
  end

  always_comb begin
    bus.sa_c = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        bus.sa_c[(i*8+j)*16 +: 16] = acc[i][j];
  end

  logic [63:0]   tb_a [8];
  logic [63:0]   tb_b [8];
  logic [1023:0] exp_c;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 1: A = I, B[k][j] = 8k+j; mode 2: A[i][k] = 16i+k, same B; mode 3: all 255
  task automatic set_mats(input int mode);
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        case (mode)
          1: begin tb_a[k][n*8 +: 8] = (n == k) ? 8'd1 : 8'd0;  tb_b[k][n*8 +: 8] = 8'(8*k + n); end
          2: begin tb_a[k][n*8 +: 8] = 8'(16*n + k);            tb_b[k][n*8 +: 8] = 8'(8*k + n); end
          default: begin tb_a[k][n*8 +: 8] = 8'hff;             tb_b[k][n*8 +: 8] = 8'hff; end
        endcase
      end
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        exp_c[(i*8+j)*16 +: 16] = (mode == 1) ? 16'(8*i + j) : 16'd61448;
  endtask

  task automatic load(input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        tick();
        check("gap_in_ready", bus.in_ready, 1'b1);
      end
      bus.in_valid = 1'b1;
      bus.in_a     = tb_a[k];
      bus.in_b     = tb_b[k];
      tick();
    end
    bus.in_valid = 1'b0;
    check("in_ready_after_last_beat", bus.in_ready, 1'b0);
    check("busy_after_load", bus.busy, 1'b1);
  endtask

  task automatic wait_done(input int start);
    int n;
    n = start;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("latency", n, 24);
  endtask

  task automatic take_result();
    check("out_c", bus.out_c, exp_c);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_accept", bus.out_valid, 1'b0);
    check("busy_after_accept", bus.busy, 1'b0);
    check("in_ready_after_accept", bus.in_ready, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_sa_a", bus.sa_a, 64'h0);
    check("rst_sa_b", bus.sa_b, 64'h0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_c", bus.out_c, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sa_rst_n", bus.sa_rst_n, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_sa_rst_n", bus.sa_rst_n, 1'b1);
    check("rel_in_ready", bus.in_ready, 1'b1);
    tick();

    // identity A
    set_mats(1);
    load(1'b0);
    check("clear_sa_rst_n", bus.sa_rst_n, 1'b0);
    wait_done(0);
    take_result();

    // skew
    set_mats(2);
    load(1'b0);
    repeat (4) tick();
    check("skew_t3_sa_a", bus.sa_a, 64'h0000_0000_3021_1203);
    check("skew_t3_sa_b", bus.sa_b, 64'h0000_0000_030a_1118);
    repeat (11) tick();
    check("skew_t14_sa_a", bus.sa_a, 64'h7700_0000_0000_0000);
    check("skew_t14_sa_b", bus.sa_b, 64'h3f00_0000_0000_0000);
    tick();
    check("drain_sa_a", bus.sa_a, 64'h0);
    wait_done(16);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // all 255, then hold result under backpressure
    set_mats(3);
    load(1'b0);
    wait_done(0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_out_c", bus.out_c, exp_c);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    take_result();

    // gapped load gives the identity result
    set_mats(1);
    load(1'b1);
    wait_done(0);
    take_result();

    // abort at feed t=5, then a clean reload
    load(1'b0);
    repeat (6) tick();
    check("feed_t5_sa_b", bus.sa_b, 64'h0000_050c_131a_2128);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sa_rst_n", bus.sa_rst_n, 1'b0);
    check("abort_sa_b", bus.sa_b, 64'h0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    tick();
    check("post_abort_sa_rst_n", bus.sa_rst_n, 1'b1);
    load(1'b0);
    wait_done(0);
    take_result();

    // async reset mid-load discards the partial load
    set_mats(3);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = tb_a[k];
      bus.in_b     = tb_b[k];
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_load_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_sa_rst_n", bus.sa_rst_n, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 1'b1);
    load(1'b0);
    wait_done(0);
    take_result();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
